proc_control_unit: RTL

- Control FSM that drives the processor Datapath control interface: D_Addr, D_Wr, RF_s, RF_W_Addr, RF_W_en, RF_Ra_Addr, RF_Rb_Addr, ALU_s0.
- Fetches 16-bit instructions from instruction memory through a program counter, decodes them, and sequences per-instruction control.
- Sits between instruction ROM and Datapath. It is the initiator of every Datapath read and write.

---
 rtl/proc_control_unit.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/proc_control_unit.sv
// ---------------------------------------------------------------------------
// proc_control_unit
//
// Control FSM for a small 16-bit processor. It fetches instructions from an
// instruction ROM via a program counter, decodes them, and drives the
// Datapath control interface cycle by cycle. All Datapath reads and writes
// originate here.
//
// Optional build macro:
//   PROC_STEP_EN  - adds a Step input. FETCH then waits for a rising edge of
//                   Step before it loads IR and advances the PC, so exactly
//                   one instruction runs per Step edge.
//
// Parameters:
//   PC_W        program counter / instruction address width
//
// Ports:
//   Clock       in   system clock, rising edge
//   Reset_n     in   asynchronous active-low reset
//   Step        in   single-step request (only with PROC_STEP_EN)
//   IR_In       in   instruction word at PC_Addr (combinational ROM read)
//   PC_Addr     out  instruction address
//   D_Addr      out  data memory address
//   D_Wr        out  data memory write enable
//   RF_s        out  register-file write mux select (0=ALU, 1=memory)
//   RF_W_Addr   out  register write address
//   RF_W_en     out  register write enable
//   RF_Ra_Addr  out  register A read address
//   RF_Rb_Addr  out  register B read address
//   ALU_s0      out  ALU op (0=pass A, 1=A+B, 2=A-B)
//   State       out  current FSM state (debug)
//   Halted      out  high while in HALT
// ---------------------------------------------------------------------------
module proc_control_unit #(
    parameter int PC_W = 7
) (
    input  logic            Clock,
    input  logic            Reset_n,
`ifdef PROC_STEP_EN
    input  logic            Step,
`endif
    input  logic [15:0]     IR_In,
    output logic [PC_W-1:0] PC_Addr,
    output logic [7:0]      D_Addr,
    output logic            D_Wr,
    output logic            RF_s,
    output logic [3:0]      RF_W_Addr,
    output logic            RF_W_en,
    output logic [3:0]      RF_Ra_Addr,
    output logic [3:0]      RF_Rb_Addr,
    output logic [2:0]      ALU_s0,
    output logic [3:0]      State,
    output logic            Halted
);

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_NOOP   = 4'd3,
        S_LOAD_A = 4'd4,
        S_LOAD_B = 4'd5,
        S_STORE  = 4'd6,
        S_ADD    = 4'd7,
        S_SUB    = 4'd8,
        S_HALT   = 4'd9
    } state_t;

    localparam logic [3:0] OP_STORE = 4'h1;
    localparam logic [3:0] OP_LOAD  = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_HALT  = 4'h5;

    localparam logic [2:0] ALU_ADD = 3'd1;
    localparam logic [2:0] ALU_SUB = 3'd2;

    state_t            state_q, state_d;
    logic [15:0]       ir_q, ir_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic              fetch_go;
    logic [3:0]        opcode;

    assign opcode = ir_q[15:12];

    // -----------------------------------------------------------------------
    // Fetch gating: free-running by default, edge-triggered by Step when the
    // single-step feature is built in.
    // -----------------------------------------------------------------------
`ifdef PROC_STEP_EN
    logic step_prev_q;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            step_prev_q <= 1'b0;
        end else begin
            step_prev_q <= Step;
        end
    end

    assign fetch_go = Step & ~step_prev_q;
`else
    assign fetch_go = 1'b1;
`endif

    // -----------------------------------------------------------------------
    // State, instruction and program counter registers
    // -----------------------------------------------------------------------
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_INIT;
            ir_q    <= 16'h0000;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            pc_q    <= pc_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic. IR and PC only change in FETCH, so the PC advances
    // exactly once per instruction and is naturally frozen in HALT.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        pc_d    = pc_q;

        case (state_q)
            S_INIT: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (fetch_go) begin
                    ir_d    = IR_In;
                    // Wraps from all-ones to zero by natural overflow.
                    pc_d    = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_STORE: state_d = S_STORE;
                    OP_LOAD:  state_d = S_LOAD_A;
                    OP_ADD:   state_d = S_ADD;
                    OP_SUB:   state_d = S_SUB;
                    OP_HALT:  state_d = S_HALT;
                    default:  state_d = S_NOOP;  // 0 and 6..F
                endcase
            end
            S_NOOP:   state_d = S_FETCH;
            S_LOAD_A: state_d = S_LOAD_B;
            S_LOAD_B: state_d = S_FETCH;
            S_STORE:  state_d = S_FETCH;
            S_ADD:    state_d = S_FETCH;
            S_SUB:    state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            // Unused encodings restart cleanly rather than lock up.
            default:  state_d = S_INIT;
        endcase
    end

    // -----------------------------------------------------------------------
    // Moore outputs, decoded from the state and IR registers only. Because
    // both registers clear asynchronously, every enable drops the instant
    // Reset_n is asserted.
    // -----------------------------------------------------------------------
    always_comb begin
        D_Addr     = 8'h00;
        D_Wr       = 1'b0;
        RF_s       = 1'b0;
        RF_W_Addr  = 4'h0;
        RF_W_en    = 1'b0;
        RF_Ra_Addr = 4'h0;
        RF_Rb_Addr = 4'h0;
        ALU_s0     = 3'd0;
        Halted     = 1'b0;

        case (state_q)
            S_LOAD_A: begin
                // Address is presented one cycle early to cover the
                // synchronous data memory read.
                D_Addr    = ir_q[11:4];
                RF_s      = 1'b1;
                RF_W_Addr = ir_q[3:0];
            end
            S_LOAD_B: begin
                D_Addr    = ir_q[11:4];
                RF_s      = 1'b1;
                RF_W_Addr = ir_q[3:0];
                RF_W_en   = 1'b1;
            end
            S_STORE: begin
                D_Addr     = ir_q[11:4];
                RF_Ra_Addr = ir_q[3:0];
                D_Wr       = 1'b1;
            end
            S_ADD: begin
                RF_Ra_Addr = ir_q[11:8];
                RF_Rb_Addr = ir_q[7:4];
                RF_W_Addr  = ir_q[3:0];
                ALU_s0     = ALU_ADD;
                RF_W_en    = 1'b1;
            end
            S_SUB: begin
                RF_Ra_Addr = ir_q[11:8];
                RF_Rb_Addr = ir_q[7:4];
                RF_W_Addr  = ir_q[3:0];
                ALU_s0     = ALU_SUB;
                RF_W_en    = 1'b1;
            end
            S_HALT: begin
                Halted = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign PC_Addr = pc_q;
    assign State   = state_q;

endmodule
